// File: rtl/draw_pkg.sv
`default_nettype none
// ============================================================================
// Module   : draw_pkg
// Brief    : Shared constants and FSM encoding for the draw command queue.
// Revision : 1.0 - initial release
// ============================================================================
package draw_pkg;

    localparam int          DRAW_X_WIDTH         = 6;
    localparam int          DRAW_Y_WIDTH         = 6;
    localparam logic [5:0]  DRAW_X_MAX           = 6'd63;
    localparam logic [5:0]  DRAW_Y_MAX           = 6'd47;
    localparam int          DRAW_COLOR_WIDTH     = 8;
    localparam int          DRAW_FIFO_DEPTH_LOG2 = 3;
    localparam logic [19:0] DRAW_WAIT_TIMEOUT    = 20'd400000;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } draw_state_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Brief    : Single-clock circular-buffer FIFO with occupancy count.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  push_i,
    input  logic [WIDTH-1:0]      data_i,
    input  logic                  pop_i,
    output logic [WIDTH-1:0]      data_o,
    output logic [DEPTH_LOG2:0]   level_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q;
    logic [DEPTH_LOG2-1:0] rd_ptr_q;
    logic [DEPTH_LOG2:0]   level_q;
    logic                  do_push;
    logic                  do_pop;

    assign full_o  = (level_q == (DEPTH_LOG2 + 1)'(DEPTH));
    assign empty_o = (level_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointers are exactly DEPTH_LOG2 wide, so the increment wraps modulo depth.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                level_q <= level_q + 1'b1;
            end else if (do_pop && !do_push) begin
                level_q <= level_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign level_o = level_q;

endmodule
`default_nettype wire

// File: rtl/draw_cmd_queue.sv
`default_nettype none
// ============================================================================
// Module   : draw_cmd_queue
// Brief    : Buffers, normalises and range-checks rectangle commands, then
//            issues them one at a time to the superpixel rectangle drawer.
// Revision : 1.0 - initial release
// ============================================================================
module draw_cmd_queue
    import draw_pkg::*;
#(
    parameter int                        SPIXEL_X_WIDTH  = DRAW_X_WIDTH,
    parameter int                        SPIXEL_Y_WIDTH  = DRAW_Y_WIDTH,
    parameter logic [SPIXEL_X_WIDTH-1:0] SPIXEL_X_MAX    = DRAW_X_MAX,
    parameter logic [SPIXEL_Y_WIDTH-1:0] SPIXEL_Y_MAX    = DRAW_Y_MAX,
    parameter int                        COLOR_ID_WIDTH  = DRAW_COLOR_WIDTH,
    parameter int                        FIFO_DEPTH_LOG2 = DRAW_FIFO_DEPTH_LOG2,
    parameter logic [19:0]               WAIT_TIMEOUT    = DRAW_WAIT_TIMEOUT
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [SPIXEL_X_WIDTH-1:0]  cmd_x0_i,
    input  logic [SPIXEL_X_WIDTH-1:0]  cmd_x1_i,
    input  logic [SPIXEL_Y_WIDTH-1:0]  cmd_y0_i,
    input  logic [SPIXEL_Y_WIDTH-1:0]  cmd_y1_i,
    input  logic [COLOR_ID_WIDTH-1:0]  cmd_color_i,
    input  logic                       cmd_valid_i,
    output logic                       cmd_ready_o,
    output logic [SPIXEL_X_WIDTH-1:0]  dr_x0_o,
    output logic [SPIXEL_Y_WIDTH-1:0]  dr_y0_o,
    output logic [SPIXEL_X_WIDTH-1:0]  dr_x1_o,
    output logic [SPIXEL_Y_WIDTH-1:0]  dr_y1_o,
    output logic [COLOR_ID_WIDTH-1:0]  dr_data_o,
    output logic                       dr_vld_o,
    input  logic                       dr_done_i,
    output logic                       busy_o,
    output logic [FIFO_DEPTH_LOG2:0]   level_o,
    output logic                       err_range_o,
    output logic                       err_timeout_o,
    input  logic                       err_clr_i
);

    localparam int CMD_WIDTH = 2 * SPIXEL_X_WIDTH + 2 * SPIXEL_Y_WIDTH + COLOR_ID_WIDTH;

    logic [SPIXEL_X_WIDTH-1:0] x_lo, x_hi;
    logic [SPIXEL_Y_WIDTH-1:0] y_lo, y_hi;
    logic                      x_oor, y_oor;
    logic                      accept, push;
    logic [CMD_WIDTH-1:0]      push_word, head_word;
    logic                      fifo_full, fifo_empty;

    draw_state_t               state_q, state_d;
    logic [19:0]               wait_cnt_q;
    logic                      timeout_hit;
    logic                      pop, cnt_clr, cnt_inc, timeout_set, range_set;

    logic [SPIXEL_X_WIDTH-1:0] dr_x0_q, dr_x1_q;
    logic [SPIXEL_Y_WIDTH-1:0] dr_y0_q, dr_y1_q;
    logic [COLOR_ID_WIDTH-1:0] dr_data_q;
    logic                      err_range_q, err_timeout_q;

    // When the legal maximum is the all-ones code no input can exceed it.
    generate
        if (SPIXEL_X_MAX == {SPIXEL_X_WIDTH{1'b1}}) begin : g_x_full_range
            assign x_oor = 1'b0;
        end else begin : g_x_range_chk
            assign x_oor = (cmd_x0_i > SPIXEL_X_MAX) || (cmd_x1_i > SPIXEL_X_MAX);
        end
        if (SPIXEL_Y_MAX == {SPIXEL_Y_WIDTH{1'b1}}) begin : g_y_full_range
            assign y_oor = 1'b0;
        end else begin : g_y_range_chk
            assign y_oor = (cmd_y0_i > SPIXEL_Y_MAX) || (cmd_y1_i > SPIXEL_Y_MAX);
        end
    endgenerate

    assign x_lo      = (cmd_x0_i < cmd_x1_i) ? cmd_x0_i : cmd_x1_i;
    assign x_hi      = (cmd_x0_i < cmd_x1_i) ? cmd_x1_i : cmd_x0_i;
    assign y_lo      = (cmd_y0_i < cmd_y1_i) ? cmd_y0_i : cmd_y1_i;
    assign y_hi      = (cmd_y0_i < cmd_y1_i) ? cmd_y1_i : cmd_y0_i;
    assign push_word = {x_lo, y_lo, x_hi, y_hi, cmd_color_i};

    assign cmd_ready_o = !fifo_full;
    assign accept      = cmd_valid_i && cmd_ready_o;
    assign push        = accept && !(x_oor || y_oor);
    assign range_set   = accept && (x_oor || y_oor);

    sync_fifo #(
        .WIDTH      (CMD_WIDTH),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .data_i  (push_word),
        .pop_i   (pop),
        .data_o  (head_word),
        .level_o (level_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign timeout_hit = (WAIT_TIMEOUT != 20'd0) && (wait_cnt_q == WAIT_TIMEOUT);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (!fifo_empty) state_d = ISSUE;
            ISSUE:     state_d = WAIT_DONE;
            WAIT_DONE: if (dr_done_i || timeout_hit) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // A done pulse wins over a simultaneous timeout.
    always_comb begin
        dr_vld_o    = 1'b0;
        pop         = 1'b0;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;
        timeout_set = 1'b0;
        case (state_q)
            IDLE:      pop = !fifo_empty;
            ISSUE: begin
                dr_vld_o = 1'b1;
                cnt_clr  = 1'b1;
            end
            WAIT_DONE: begin
                timeout_set = !dr_done_i && timeout_hit;
                cnt_inc     = !dr_done_i && !timeout_hit;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dr_x0_q       <= '0;
            dr_y0_q       <= '0;
            dr_x1_q       <= '0;
            dr_y1_q       <= '0;
            dr_data_q     <= '0;
            wait_cnt_q    <= '0;
            err_range_q   <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            if (pop) begin
                {dr_x0_q, dr_y0_q, dr_x1_q, dr_y1_q, dr_data_q} <= head_word;
            end
            if (cnt_clr) begin
                wait_cnt_q <= '0;
            end else if (cnt_inc) begin
                wait_cnt_q <= wait_cnt_q + 20'd1;
            end
            err_range_q   <= range_set   | (err_range_q   & ~err_clr_i);
            err_timeout_q <= timeout_set | (err_timeout_q & ~err_clr_i);
        end
    end

    assign dr_x0_o       = dr_x0_q;
    assign dr_y0_o       = dr_y0_q;
    assign dr_x1_o       = dr_x1_q;
    assign dr_y1_o       = dr_y1_q;
    assign dr_data_o     = dr_data_q;
    assign busy_o        = (state_q != IDLE) || !fifo_empty;
    assign err_range_o   = err_range_q;
    assign err_timeout_o = err_timeout_q;

endmodule
`default_nettype wire
